// File: rtl/syn_fft_pkg.sv
// Shared types and defaults for the FFT ping-pong frame buffer.
//   bank_state_t  : life cycle of one frame bank
//   rd_fsm_t      : read-side sequencer states
//   DEF_*         : default sample width and frame length
//   bank_writable : true when the write side may store into a bank
package syn_fft_pkg;

  localparam int DEF_SAMPLE_W    = 16;
  localparam int DEF_NUM_SAMPLES = 128;

  typedef enum logic [1:0] {
    BANK_EMPTY    = 2'd0,
    BANK_FILLING  = 2'd1,
    BANK_FULL     = 2'd2,
    BANK_DRAINING = 2'd3
  } bank_state_t;

  typedef enum logic {
    RD_IDLE  = 1'b0,
    RD_DRAIN = 1'b1
  } rd_fsm_t;

  function automatic logic bank_writable(input bank_state_t s);
    return (s == BANK_EMPTY) || (s == BANK_FILLING);
  endfunction

endpackage

// File: rtl/syn_fft_frame_ram.sv
// Simple dual-port sample memory holding both frame banks.
//   clk_ir, rst_il       : clock, async active-low reset (read register only)
//   wr_en/wr_addr/wr_data: write port, address is {bank, idx}
//   rd_en/rd_addr        : read request, data appears one cycle later
//   rd_data              : registered read data, held while rd_en is low
module syn_fft_frame_ram #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8
) (
  input  logic              clk_ir,
  input  logic              rst_il,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rd_data_q;

  always_ff @(posedge clk_ir) begin
    if (wr_en) mem_q[wr_addr] <= wr_data;
  end

  // The read register only advances on a read request, so the buffer above
  // can treat it as a storage slot that holds its value while stalled.
  always_ff @(posedge clk_ir or negedge rst_il) begin
    if (!rst_il)    rd_data_q <= '0;
    else if (rd_en) rd_data_q <= mem_q[rd_addr];
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/syn_fft_frame_buf.sv
// Ping-pong frame buffer between PCM capture and the FFT engine.
//   clk_ir, rst_il          : clock, async active-low reset
//   capture_en              : capture enable, low aborts the filling frame
//   pcm_valid, pcm_data     : sample strobe and data, no backpressure
//   fft_valid, fft_ready    : output handshake
//   fft_data, fft_idx       : output sample and its index within the frame
//   fft_sof, fft_eof        : first / last sample of a frame
//   frame_cnt               : frames fully emitted (wraps)
//   ovrflw_cnt              : dropped input samples (saturates)
//   rd_state_dbg            : current read sequencer state
//
// Output handshake: a sample transfers on a rising edge where fft_valid and
// fft_ready are both high; once fft_valid is raised it and all sideband
// outputs stay unchanged until that transfer happens.
module syn_fft_frame_buf
  import syn_fft_pkg::*;
#(
  parameter int SAMPLE_W    = DEF_SAMPLE_W,
  parameter int NUM_SAMPLES = DEF_NUM_SAMPLES,
  parameter int IDX_W       = $clog2(NUM_SAMPLES)
) (
  input  logic                       clk_ir,
  input  logic                       rst_il,
  input  logic                       capture_en,
  input  logic                       pcm_valid,
  input  logic signed [SAMPLE_W-1:0] pcm_data,
  output logic                       fft_valid,
  input  logic                       fft_ready,
  output logic signed [SAMPLE_W-1:0] fft_data,
  output logic                       fft_sof,
  output logic                       fft_eof,
  output logic [IDX_W-1:0]           fft_idx,
  output logic [15:0]                frame_cnt,
  output logic [15:0]                ovrflw_cnt,
  output rd_fsm_t                    rd_state_dbg
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SAMPLES - 1);

  // Registered state
  bank_state_t [1:0]   bank_state_q, bank_state_d;
  logic                wr_bank_q, wr_bank_d;
  logic [IDX_W-1:0]    wr_idx_q, wr_idx_d;
  logic                rd_bank_q, rd_bank_d;
  logic [IDX_W-1:0]    rd_idx_q, rd_idx_d;
  rd_fsm_t             rd_state_q, rd_state_d;
  logic [15:0]         frame_cnt_q, frame_cnt_d;
  logic [15:0]         ovrflw_q, ovrflw_d;
  logic                m_vld_q, m_vld_d;
  logic [IDX_W-1:0]    m_idx_q, m_idx_d;
  logic                s_vld_q, s_vld_d;
  logic [SAMPLE_W-1:0] skid_data_q, skid_data_d;
  logic [IDX_W-1:0]    skid_idx_q, skid_idx_d;

  // Combinational helpers
  logic                wr_accept;
  logic                wr_drop;
  logic                rd_issue;
  logic [IDX_W-1:0]    rd_sel_idx;
  logic [SAMPLE_W-1:0] ram_rdata;
  logic                out_valid;
  logic [SAMPLE_W-1:0] head_data;
  logic [IDX_W-1:0]    head_idx;
  logic                pop;
  logic                pop_s;
  logic                pop_m;
  logic                main_keep;
  logic                can_read;
  logic                eof_pop;

  syn_fft_frame_ram #(
    .DATA_W (SAMPLE_W),
    .ADDR_W (IDX_W + 1)
  ) u_ram (
    .clk_ir  (clk_ir),
    .rst_il  (rst_il),
    .wr_en   (wr_accept),
    .wr_addr ({wr_bank_q, wr_idx_q}),
    .wr_data (pcm_data),
    .rd_en   (rd_issue),
    .rd_addr ({rd_bank_q, rd_sel_idx}),
    .rd_data (ram_rdata)
  );

  // Output stage. Two slots: "main" is the RAM read register itself and
  // "skid" holds an older sample that had to move out of the way when a new
  // read was issued. The skid slot, when occupied, is always the head.
  always_comb begin
    out_valid = s_vld_q || m_vld_q;
    head_data = '0;
    head_idx  = '0;
    if (s_vld_q) begin
      head_data = skid_data_q;
      head_idx  = skid_idx_q;
    end else if (m_vld_q) begin
      head_data = ram_rdata;
      head_idx  = m_idx_q;
    end
    pop       = out_valid && fft_ready;
    pop_s     = pop && s_vld_q;
    pop_m     = pop && !s_vld_q;
    main_keep = m_vld_q && !pop_m;
    // A read may be issued unless both slots stay occupied this cycle.
    can_read  = !(s_vld_q && m_vld_q) || pop;
    eof_pop   = pop && (head_idx == LAST_IDX);
  end

  // Write side, read sequencer and counters.
  always_comb begin
    bank_state_d = bank_state_q;
    wr_bank_d    = wr_bank_q;
    wr_idx_d     = wr_idx_q;
    rd_bank_d    = rd_bank_q;
    rd_idx_d     = rd_idx_q;
    rd_state_d   = rd_state_q;
    frame_cnt_d  = frame_cnt_q;
    ovrflw_d     = ovrflw_q;
    rd_issue     = 1'b0;
    rd_sel_idx   = (rd_state_q == RD_IDLE) ? '0 : rd_idx_q;

    wr_accept = pcm_valid && capture_en && bank_writable(bank_state_q[wr_bank_q]);
    wr_drop   = pcm_valid && capture_en && !bank_writable(bank_state_q[wr_bank_q]);

    if (!capture_en) begin
      wr_idx_d = '0;
      if (bank_state_q[0] == BANK_FILLING) bank_state_d[0] = BANK_EMPTY;
      if (bank_state_q[1] == BANK_FILLING) bank_state_d[1] = BANK_EMPTY;
    end else if (wr_accept) begin
      if (wr_idx_q == LAST_IDX) begin
        bank_state_d[wr_bank_q] = BANK_FULL;
        wr_idx_d                = '0;
        wr_bank_d               = !wr_bank_q;
      end else begin
        bank_state_d[wr_bank_q] = BANK_FILLING;
        wr_idx_d                = wr_idx_q + IDX_W'(1);
      end
    end

    if (wr_drop && (ovrflw_q != 16'hFFFF)) ovrflw_d = ovrflw_q + 16'd1;

    // The write side only touches EMPTY/FILLING banks and the read side only
    // FULL/DRAINING ones, so the two updates below never collide.
    case (rd_state_q)
      RD_IDLE: begin
        if (bank_state_q[rd_bank_q] == BANK_FULL) begin
          bank_state_d[rd_bank_q] = BANK_DRAINING;
          rd_state_d              = RD_DRAIN;
          rd_idx_d                = '0;
          // Start the first read right away to reach SOF two cycles after
          // the last sample was written.
          if (can_read) begin
            rd_issue = 1'b1;
            rd_idx_d = IDX_W'(1);
          end
        end
      end
      RD_DRAIN: begin
        if (can_read) begin
          rd_issue = 1'b1;
          rd_idx_d = rd_idx_q + IDX_W'(1);
          if (rd_idx_q == LAST_IDX) rd_state_d = RD_IDLE;
        end
      end
      default: rd_state_d = RD_IDLE;
    endcase

    // The bank is only released once its last sample has left the block.
    if (eof_pop) begin
      bank_state_d[rd_bank_q] = BANK_EMPTY;
      rd_bank_d               = !rd_bank_q;
      frame_cnt_d             = frame_cnt_q + 16'd1;
    end
  end

  // Output slot bookkeeping.
  always_comb begin
    m_vld_d     = m_vld_q && !pop_m;
    m_idx_d     = m_idx_q;
    s_vld_d     = s_vld_q && !pop_s;
    skid_data_d = skid_data_q;
    skid_idx_d  = skid_idx_q;
    if (rd_issue) begin
      m_vld_d = 1'b1;
      m_idx_d = rd_sel_idx;
      // The RAM register is about to be overwritten: park its unsent sample.
      if (main_keep) begin
        s_vld_d     = 1'b1;
        skid_data_d = ram_rdata;
        skid_idx_d  = m_idx_q;
      end
    end
  end

  always_ff @(posedge clk_ir or negedge rst_il) begin
    if (!rst_il) begin
      bank_state_q <= {BANK_EMPTY, BANK_EMPTY};
      wr_bank_q    <= 1'b0;
      wr_idx_q     <= '0;
      rd_bank_q    <= 1'b0;
      rd_idx_q     <= '0;
      rd_state_q   <= RD_IDLE;
      frame_cnt_q  <= '0;
      ovrflw_q     <= '0;
      m_vld_q      <= 1'b0;
      m_idx_q      <= '0;
      s_vld_q      <= 1'b0;
      skid_data_q  <= '0;
      skid_idx_q   <= '0;
    end else begin
      bank_state_q <= bank_state_d;
      wr_bank_q    <= wr_bank_d;
      wr_idx_q     <= wr_idx_d;
      rd_bank_q    <= rd_bank_d;
      rd_idx_q     <= rd_idx_d;
      rd_state_q   <= rd_state_d;
      frame_cnt_q  <= frame_cnt_d;
      ovrflw_q     <= ovrflw_d;
      m_vld_q      <= m_vld_d;
      m_idx_q      <= m_idx_d;
      s_vld_q      <= s_vld_d;
      skid_data_q  <= skid_data_d;
      skid_idx_q   <= skid_idx_d;
    end
  end

  assign fft_valid    = out_valid;
  assign fft_data     = head_data;
  assign fft_idx      = head_idx;
  assign fft_sof      = out_valid && (head_idx == '0);
  assign fft_eof      = out_valid && (head_idx == LAST_IDX);
  assign frame_cnt    = frame_cnt_q;
  assign ovrflw_cnt   = ovrflw_q;
  assign rd_state_dbg = rd_state_q;

endmodule

// File: doc/syn_fft_frame_buf.md
# syn_fft_frame_buf

Ping-pong frame buffer between the audio capture path and the FFT engine. It collects a stream of signed PCM samples into frames of `NUM_SAMPLES` and streams each complete frame to the FFT stage with valid/ready, start-of-frame and end-of-frame markers. While one bank drains, the other bank fills. The verification environment's DPI FFT reference model takes exactly one emitted frame per call.

## Interface
- `SAMPLE_W`, default 16: signed PCM sample width.
- `NUM_SAMPLES`, default 128: frame length. Must be a power of 2, minimum 4.
- `IDX_W`, default `$clog2(NUM_SAMPLES)`: sample index width. Derived; do not override.
- `clk_ir`, input, 1: single clock.
- `rst_il`, input, 1: asynchronous, active-low reset.
- `capture_en`, input, 1: enables sample capture. Deassertion aborts the frame being filled.
- `pcm_valid`, input, 1: one-cycle strobe marking a new sample. The source has no backpressure.
- `pcm_data`, input, `SAMPLE_W`: signed sample, valid with `pcm_valid`.
- `fft_valid`, output, 1: output sample valid.
- `fft_ready`, input, 1: FFT engine accepts the sample.
- `fft_data`, output, `SAMPLE_W`: output sample.
- `fft_sof`, output, 1: output sample is index 0 of its frame.
- `fft_eof`, output, 1: output sample is index `NUM_SAMPLES-1` of its frame.
- `fft_idx`, output, `IDX_W`: index of the output sample within its frame.
- `frame_cnt`, output, 16: number of frames fully emitted. Wraps at 0xFFFF.
- `ovrflw_cnt`, output, 16: number of dropped input samples. Saturates at 0xFFFF.

## Operation
- Two banks, each `NUM_SAMPLES` deep. Each bank has a state: EMPTY, FILLING, FULL or DRAINING.
- **Write side.** Registers `wr_bank` and `wr_idx`.
  - A sample is accepted when `pcm_valid` and `capture_en` are both high and bank `wr_bank` is EMPTY or FILLING.
  - On accept, the sample is written at `wr_idx` and `wr_idx` increments.
  - When `wr_idx == NUM_SAMPLES-1` is accepted: that bank goes to FULL, `wr_idx` goes to 0, and `wr_bank` toggles.
- **Overflow.** If `pcm_valid` and `capture_en` are high while bank `wr_bank` is FULL or DRAINING, the sample is dropped and `ovrflw_cnt` increments. Nothing is written.
- **Abort.** When `capture_en` is low, `wr_idx` is forced to 0 and a FILLING bank returns to EMPTY. FULL and DRAINING banks are not affected.
- **Read FSM: IDLE.** When `rd_bank` is FULL, mark it DRAINING, set `rd_idx` to 0 and go to DRAIN. The read bank always alternates, so frame order is preserved.
- **Read FSM: DRAIN.** Issue one RAM read per cycle while the output stage has space.
  - After the read of index `NUM_SAMPLES-1` is issued, return to IDLE.
  - The bank returns to EMPTY and `rd_bank` toggles when the EOF sample is accepted at the output (`fft_valid && fft_ready && fft_eof`).
  - `frame_cnt` increments on that same handshake.
- **Output stage.** A 2-entry skid register. `fft_data`, `fft_sof`, `fft_eof` and `fft_idx` are held stable while `fft_valid && !fft_ready`. Reads are throttled so that nothing is ever lost.
- **Simultaneous events.**
  - If bank X is released by the EOF handshake in the same cycle that a sample arrives for bank X, the sample is dropped (the bank is still DRAINING that cycle). The following sample is accepted at index 0.
  - If a write completes bank A in the same cycle the read FSM is IDLE, bank A is seen FULL on the next cycle.
- **Reset.** Asynchronous assertion clears all state mid-frame. All outputs are 0. Both banks are EMPTY. The FSM is IDLE. `wr_bank` and `rd_bank` are 0. RAM contents are don't-care.

## Timing
- RAM read latency is 1 cycle.
- If the last sample of a frame is accepted in cycle T and `fft_ready` is held high, `fft_valid` with `fft_sof` is asserted in cycle T+2. The remaining samples follow one per cycle, so EOF is at T+1+`NUM_SAMPLES`.
- Sustained throughput is 1 sample per cycle with `fft_ready` high.
- After `fft_ready` deasserts, at most 2 further samples are read into the skid register.
- `fft_valid` never drops without a handshake.

## Structure
- Shared package `syn_fft_pkg` holds:
  - the `bank_state_t` enum (EMPTY, FILLING, FULL, DRAINING);
  - the `rd_fsm_t` enum (IDLE, DRAIN);
  - default constants for `SAMPLE_W` and `NUM_SAMPLES`.
- Sub-module `syn_fft_frame_ram`: simple dual-port memory, depth `2*NUM_SAMPLES`, registered read. The address is `{bank, idx}`.

## Test plan
- **Basic frame.** `NUM_SAMPLES`=8. Feed samples 0..7 with `fft_ready`=1. Expect `fft_data` 0..7 on consecutive cycles starting 2 cycles after the 8th sample. `fft_sof` is set at index 0, `fft_eof` at index 7, and `frame_cnt` becomes 1.
- **Backpressure.** Toggle `fft_ready` randomly at 50% over 4 frames of ramp data. Expect no loss, duplication or reorder, and stable outputs while stalled.
- **Overflow.** Hold `fft_ready`=0 and feed 3 frames of 8 samples (24 samples). Expect `ovrflw_cnt`=8. Releasing `fft_ready` then yields exactly frames 1 and 2.
- **Abort.** Feed 5 samples, drop `capture_en` for 1 cycle, re-enable and feed 8 samples 100..107. Expect a single output frame 100..107.
- **Reset mid-drain.** Assert `rst_il` at output index 3. Expect all outputs 0 immediately, no further `fft_valid`, and the next full frame emitted correctly from bank 0.
- **Saturation.** Force 70000 drops. Expect `ovrflw_cnt` to hold at 0xFFFF.
